// File: rtl/concat_pack_ctrl.sv
// concat_pack_ctrl: packs IN_W-bit chunks LSB-first into OUT_W words; define CONCAT_PACK_FLUSH_EN for the flush port
module concat_pack_ctrl #(
  parameter int IN_W = 4,
  parameter int RATIO = 4,
  localparam int OUT_W = IN_W * RATIO,
  localparam int CNT_W = $clog2(RATIO + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
`ifdef CONCAT_PACK_FLUSH_EN
  input  logic             flush,
`endif
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t state, state_n;
  logic [OUT_W-1:0] word, word_n;
  logic [CNT_W-1:0] idx, idx_n, count_n;
  logic xfer_in;
  assign in_ready = !rst && (state == ACC || out_ready);
  assign out_valid = !rst && state == HOLD;
  assign xfer_in = in_valid && in_ready;
  assign out_data = word;
  // state, word buffer, slot index and completed-word chunk count
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      word <= '0;
      idx <= '0;
      out_count <= '0;
    end else begin
      state <= state_n;
      word <= word_n;
      idx <= idx_n;
      out_count <= count_n;
    end
  end
  // next state: append chunks in ACC; in HOLD the leaving word is cleared and a same-cycle chunk starts slot 0
  always_comb begin
    state_n = state;
    word_n = word;
    idx_n = idx;
    count_n = out_count;
    if (state == ACC) begin
      if (xfer_in) begin
        for (int k = 0; k < RATIO; k++)
          if (idx == CNT_W'(k)) word_n[k*IN_W +: IN_W] = in_data;
        idx_n = idx + 1'b1;
      end
      if (xfer_in && idx == CNT_W'(RATIO - 1)) begin
        state_n = HOLD;
        count_n = CNT_W'(RATIO);
        idx_n = '0;
      end
`ifdef CONCAT_PACK_FLUSH_EN
      else if (flush && (xfer_in || idx != '0)) begin
        state_n = HOLD;
        count_n = idx + {{(CNT_W-1){1'b0}}, xfer_in};
        idx_n = '0;
      end
`endif
    end else if (out_ready) begin
      state_n = ACC;
      word_n = '0;
      idx_n = xfer_in ? CNT_W'(1) : '0;
      if (xfer_in) word_n[IN_W-1:0] = in_data;
    end
  end
endmodule

// File: tb/tb_concat_pack_ctrl.sv
// tb_concat_pack_ctrl: directed and scoreboard checks for concat_pack_ctrl (IN_W=4, RATIO=4)
module tb_concat_pack_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, flush = 0;
  logic in_ready, out_valid;
  logic [3:0] in_data = 0;
  logic [15:0] out_data;
  logic [2:0] out_count;
  int n_cmp = 0, n_bad = 0;

  concat_pack_ctrl #(.IN_W(4), .RATIO(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef CONCAT_PACK_FLUSH_EN
    .flush(flush),
`endif
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] d, input logic r);
    @(negedge clk);
    in_valid = v;
    in_data = d;
    out_ready = r;
    #1;
  endtask

  task automatic test_reset;
    rst = 1;
    drive(1, 4'h5, 1);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    drive(0, 0, 0);
    @(negedge clk);
    rst = 0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_count !== 3'd0) begin n_bad++; $display("FAIL post_rst_out_count got %0d want 0", out_count); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL post_rst_out_data got %h want 0000", out_data); end
  endtask

  task automatic test_basic;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 4'(i), 1);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready[%0d] got %b want 1", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_out_valid[%0d] got %b want 0", i, out_valid); end
    end
    drive(0, 0, 0);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h4321) begin n_bad++; $display("FAIL basic_data got %h want 4321", out_data); end
    n_cmp++; if (out_count !== 3'd4) begin n_bad++; $display("FAIL basic_count got %0d want 4", out_count); end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'hE, 0);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready[%0d] got %b want 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== 16'h4321) begin n_bad++; $display("FAIL hold_data[%0d] got %h want 4321", i, out_data); end
    end
    drive(1, 4'hE, 1);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    drive(1, 4'hF, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release_valid got %b want 0", out_valid); end
    drive(1, 4'h1, 1);
    drive(1, 4'h2, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release_early_valid got %b want 0", out_valid); end
    drive(0, 0, 1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL release_word_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h21FE) begin n_bad++; $display("FAIL release_word_data got %h want 21fe", out_data); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ch [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
    for (int i = 0; i <= 8; i++) begin
      drive(i < 8, i < 8 ? ch[i] : 4'h0, 1);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
      n_cmp++; if (out_valid !== (i == 4 || i == 8)) begin n_bad++; $display("FAIL b2b_valid[%0d] got %b want %b", i, out_valid, (i == 4 || i == 8)); end
      if (i == 4) begin
        n_cmp++; if (out_data !== 16'hDCBA) begin n_bad++; $display("FAIL b2b_word0 got %h want dcba", out_data); end
      end
      if (i == 8) begin
        n_cmp++; if (out_data !== 16'h10FE) begin n_bad++; $display("FAIL b2b_word1 got %h want 10fe", out_data); end
      end
    end
  endtask

  task automatic test_reset_mid;
    drive(1, 4'h1, 1);
    drive(1, 4'h2, 1);
    @(negedge clk);
    rst = 1;
    in_valid = 0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    rst = 0;
    for (int i = 5; i <= 8; i++) begin
      drive(1, 4'(i), 1);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid[%0d] got %b want 0", i, out_valid); end
    end
    drive(0, 0, 1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_word_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h8765) begin n_bad++; $display("FAIL midrst_word_data got %h want 8765", out_data); end
    n_cmp++; if (out_count !== 3'd4) begin n_bad++; $display("FAIL midrst_count got %0d want 4", out_count); end
    drive(0, 0, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_extra_word got %b want 0", out_valid); end
  endtask

`ifdef CONCAT_PACK_FLUSH_EN
  task automatic test_flush;
    drive(1, 4'h9, 1);
    drive(1, 4'hA, 1);
    drive(0, 0, 0);
    flush = 1;
    drive(0, 0, 1);
    flush = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h00A9) begin n_bad++; $display("FAIL flush_data got %h want 00a9", out_data); end
    n_cmp++; if (out_count !== 3'd2) begin n_bad++; $display("FAIL flush_count got %0d want 2", out_count); end
    drive(0, 0, 1);
    flush = 1;
    drive(0, 0, 1);
    flush = 0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty got %b want 0", out_valid); end
  endtask
`endif

  task automatic test_random;
    logic [15:0] q [$];
    logic [15:0] part = 0;
    int n = 0, sent = 0, got = 0, iter = 0;
    logic [3:0] d;
    while (sent < 10000 && iter < 60000) begin
      d = 4'($urandom);
      drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0);
      iter++;
      if (out_valid && out_ready) begin
        got++;
        n_cmp++;
        if (q.size() == 0) begin n_bad++; $display("FAIL rnd_extra_word got %h want none", out_data); end
        else if (out_data !== q[0] || out_count !== 3'd4) begin
          n_bad++; $display("FAIL rnd_word got %h/%0d want %h/4", out_data, out_count, q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        part[n*4 +: 4] = d;
        n++;
        sent++;
        if (n == 4) begin q.push_back(part); part = 0; n = 0; end
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1);
      if (out_valid) begin
        got++;
        n_cmp++;
        if (q.size() == 0 || out_data !== q[0]) begin n_bad++; $display("FAIL rnd_drain_word got %h want %h", out_data, q.size() ? q[0] : 16'hx); end
        if (q.size() != 0) void'(q.pop_front());
      end
    end
    n_cmp++; if (sent != 10000) begin n_bad++; $display("FAIL rnd_budget got %0d chunks want 10000", sent); end
    n_cmp++; if (got != 2500) begin n_bad++; $display("FAIL rnd_word_count got %0d want 2500", got); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_back_to_back;
    test_reset_mid;
`ifdef CONCAT_PACK_FLUSH_EN
    test_flush;
`endif
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
